// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   alu_op_e : ALUop encodings (3 bits)
//   state_e  : control FSM states (IDLE / BUSY / DONE)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOTB = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operation/result handshake bundle of the multi-cycle ALU.
//   in_valid/in_ready   : operation offer (Ain, Bin, ALUop)
//   out_valid/out_ready : result offer (result, status = {V,N,Z})
//   master : producer/consumer side
//   slave  : ALU side
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic [2:0]       ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       status;

  modport master (
    output in_valid, Ain, Bin, ALUop, out_ready,
    input  in_ready, out_valid, result, status
  );

  modport slave (
    input  in_valid, Ain, Bin, ALUop, out_ready,
    output in_ready, out_valid, result, status
  );
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: WIDTH-bit two's-complement adder/subtractor.
//   i_a, i_b : operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_sum    : result modulo 2^WIDTH
//   o_cout   : carry out of the MSB (used by the multiply accumulation)
//   o_ovf    : signed overflow of this add/subtract
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_full;

  // Subtract as a + ~b + 1.
  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];
  // Overflow: both effective operands share a sign the result does not.
  assign o_ovf  = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : alu_mc_if slave (in_valid/in_ready/Ain/Bin/ALUop,
//            out_valid/out_ready/result/status {V,N,Z})
// Single-cycle ops (ADD SUB AND NOTB OR XOR) complete on accept. SHL shifts
// one bit per BUSY cycle; MUL is an unsigned shift-add, one multiplier bit
// per step, with bit 0 folded into the accept cycle so the result is visible
// WIDTH cycles after accept.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave io_bus
);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH-1);

  state_e           r_state;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_status;
  logic             r_in_ready;
  logic             r_out_valid;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_simple;
  logic             w_simple_v;
  logic [SHW:0]     w_shamt;
  logic [WIDTH-1:0] w_pp0;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_busy_res;
  logic             w_busy_v;

  function automatic logic [2:0] f_flags(input logic v, input logic [WIDTH-1:0] res);
    return {v, res[WIDTH-1], (res == '0)};
  endfunction

  assign w_op       = alu_op_e'(io_bus.ALUop);
  assign w_accept   = io_bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & io_bus.out_ready;
  assign w_shamt    = {1'b0, io_bus.Bin[SHW-1:0]};
  assign w_pp0      = io_bus.Bin[0] ? io_bus.Ain : '0;

  // The adder serves ADD/SUB straight from the inputs while idle and the
  // MUL accumulation from the working registers while busy.
  always_comb begin
    w_add_a   = io_bus.Ain;
    w_add_b   = io_bus.Bin;
    w_add_sub = (w_op == OP_SUB);
    if (r_state == S_BUSY) begin
      w_add_a   = r_acc;
      w_add_b   = r_mq[0] ? r_a : '0;
      w_add_sub = 1'b0;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_sub  (w_add_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  always_comb begin
    w_simple   = '0;
    w_simple_v = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_simple   = w_sum;
        w_simple_v = w_ovf;
      end
      OP_AND:  w_simple = io_bus.Ain & io_bus.Bin;
      OP_NOTB: w_simple = ~io_bus.Bin;
      OP_OR:   w_simple = io_bus.Ain | io_bus.Bin;
      OP_XOR:  w_simple = io_bus.Ain ^ io_bus.Bin;
      default: w_simple = '0;
    endcase
  end

  // Product register {r_acc, r_mq} shifts right once per step; the add
  // carry becomes the new top bit of the accumulator.
  assign w_mul_hi   = {w_cout, w_sum[WIDTH-1:1]};
  assign w_mul_lo   = {w_sum[0], r_mq[WIDTH-1:1]};
  assign w_shl      = {r_acc[WIDTH-2:0], 1'b0};
  assign w_busy_res = (r_op == OP_MUL) ? w_mul_lo : w_shl;
  assign w_busy_v   = (r_op == OP_MUL) ? (|w_mul_hi) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_acc       <= '0;
      r_mq        <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_status    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= w_op;
            r_a        <= io_bus.Ain;
            r_in_ready <= 1'b0;
            case (w_op)
              OP_SHL: begin
                r_acc <= io_bus.Ain;
                r_mq  <= io_bus.Bin;
                r_cnt <= w_shamt;
                // A zero shift has nothing to iterate over.
                if (w_shamt == '0) begin
                  r_result    <= io_bus.Ain;
                  r_status    <= f_flags(1'b0, io_bus.Ain);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
                end else begin
                  r_state <= S_BUSY;
                end
              end
              OP_MUL: begin
                // Multiplier bit 0 is applied here against a zero accumulator.
                r_acc   <= {1'b0, w_pp0[WIDTH-1:1]};
                r_mq    <= {w_pp0[0], io_bus.Bin[WIDTH-1:1]};
                r_cnt   <= CNT_MUL;
                r_state <= S_BUSY;
              end
              default: begin
                r_result    <= w_simple;
                r_status    <= f_flags(w_simple_v, w_simple);
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end
            endcase
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_op == OP_MUL) begin
            r_acc <= w_mul_hi;
            r_mq  <= w_mul_lo;
          end else begin
            r_acc <= w_shl;
          end
          if (r_cnt == CNT_ONE) begin
            r_result    <= w_busy_res;
            r_status    <= f_flags(w_busy_v, w_busy_res);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.result    = r_result;
  assign io_bus.status    = r_status;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16.
module tb_alu_mc;
  localparam int W = 16;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, NOTB = 3'b011,
                         OR_ = 3'b100, XOR_ = 3'b101, SHL = 3'b110, MUL = 3'b111;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge. Offers one op, scrambles the inputs after the
  // accept edge, and returns the number of edges (accept edge counted as 1)
  // until out_valid is seen.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.Ain      = a;
    bus.Bin      = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ALUop    = 3'b111;
    bus.Ain      = 16'hDEAD;
    bus.Bin      = 16'hBEEF;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, "_ovld_clr"}, bus.out_valid, 0);
    check_val({tag, "_irdy_set"}, bus.in_ready, 1);
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic [2:0] exp_st, input int exp_lat);
    int lat;
    check_val({tag, "_irdy"}, bus.in_ready, 1);
    run_op(op, a, b, lat);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, bus.result, exp_res);
    check_val({tag, "_st"}, bus.status, exp_st);
    consume(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    n_chk = 0;
    n_err = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;   // offered during reset; must have no effect
    bus.ALUop     = ADD;
    bus.Ain       = 16'h0001;
    bus.Bin       = 16'h0001;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_result", bus.result, 0);
    check_val("rst_status", bus.status, 0);
    check_val("rst_ovld", bus.out_valid, 0);
    check_val("rst_irdy", bus.in_ready, 1);

    // Release and offer on the very next rising edge.
    rst_n = 1'b1;
    op_check("add_ovf", ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1);
    op_check("sub_zero", SUB, 16'h0006, 16'h0006, 16'h0000, 3'b001, 1);
    op_check("notb", NOTB, 16'h1234, 16'h000A, 16'hFFF5, 3'b010, 1);
    op_check("sub_ovf", SUB, 16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1);
    op_check("and", AND_, 16'hF0F0, 16'hFF00, 16'hF000, 3'b010, 1);
    op_check("or", OR_, 16'h0F00, 16'h00F0, 16'h0FF0, 3'b000, 1);
    op_check("xor", XOR_, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b001, 1);
    op_check("mul_hi", MUL, 16'h0100, 16'h0100, 16'h0000, 3'b101, 16);
    op_check("mul_3x5", MUL, 16'h0003, 16'h0005, 16'h000F, 3'b000, 16);
    op_check("mul_max", MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b100, 16);
    op_check("shl_15", SHL, 16'h0001, 16'd15, 16'h8000, 3'b010, 16);
    op_check("shl_0", SHL, 16'h1234, 16'd0, 16'h1234, 3'b000, 1);
    op_check("shl_4", SHL, 16'h0003, 16'd4, 16'h0030, 3'b000, 5);

    // Backpressure: result holds, new offers are refused.
    run_op(ADD, 16'h0002, 16'h0003, lat);
    check_val("bp_lat", lat, 1);
    bus.in_valid = 1'b1;
    bus.ALUop    = SUB;
    bus.Ain      = 16'h0009;
    bus.Bin      = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_res_hold", bus.result, 16'h0005);
      check_val("bp_irdy_low", bus.in_ready, 0);
      check_val("bp_ovld_hold", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    check_val("bp_res_kept", bus.result, 16'h0005);
    @(negedge clk);
    check_val("bp_no_queue", bus.out_valid, 0);

    // Reset during cycle 8 of a MUL.
    run_op_start: begin
      bus.in_valid = 1'b1;
      bus.ALUop    = MUL;
      bus.Ain      = 16'h0003;
      bus.Bin      = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (7) @(negedge clk);
    end
    check_val("mr_busy_irdy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_val("mr_result", bus.result, 0);
    check_val("mr_status", bus.status, 0);
    check_val("mr_ovld", bus.out_valid, 0);
    check_val("mr_irdy", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check_val("mr_no_result", seen, 0);

    op_check("post_rst_add", ADD, 16'h0001, 16'h0001, 16'h0002, 3'b000, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
